unary_rx: RTL and testbench

UNARY_RX -- requirements
Module: unary_rx

---
 rtl/unary_rx.sv | 150 +++++++++++++++
 tb/tb_unary_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/unary_rx.sv
// Unary frame receiver: counts uin pulses between start and udone (or timeout)
// and offers the saturated count as a held result with a ready/valid handshake.
module unary_rx #(
  parameter int WIDTH   = 4,
  parameter int CW      = 2 * WIDTH,
  parameter int MAXV    = (2 ** WIDTH - 1) ** 2,
  parameter int TIMEOUT = 300
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          uin,
  input  logic          udone,
  input  logic          out_ready,
  output logic          busy,
  output logic          res_valid,
  output logic [CW-1:0] res,
  output logic          err_ovf,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MaxC     = CW'(MAXV);
  localparam logic [TW-1:0] TimeoutC = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] res_q, res_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;
  logic          ovr_q, ovr_d;

  logic          atMax;
  logic [CW-1:0] countInc;
  logic          incOvf;
  logic [TW-1:0] cycInc;
  logic          timeoutHit;

  // The count saturates at MAXV; an increment attempted there flags overflow.
  assign atMax      = (count_q >= MaxC);
  assign countInc   = (uin && !atMax) ? count_q + 1'b1 : count_q;
  assign incOvf     = uin && atMax;
  assign cycInc     = cyc_q + 1'b1;
  assign timeoutHit = (cycInc == TimeoutC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  // In COUNT a new start wins over udone, and udone wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT: begin
        if (start)                    state_d = COUNT;
        else if (udone || timeoutHit) state_d = HOLD;
      end
      HOLD:    if (out_ready) state_d = start ? COUNT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          cyc_d   = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      COUNT: begin
        if (start) begin
          count_d = '0;
          cyc_d   = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end else begin
          count_d = countInc;
          cyc_d   = cycInc;
          if (incOvf) ovf_d = 1'b1;
          if (udone) begin
            res_d = countInc;
          end else if (timeoutHit) begin
            res_d = countInc;
            tmo_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // A start while the result is still unaccepted is dropped, not queued.
        if (start) begin
          if (out_ready) begin
            count_d = '0;
            cyc_d   = '0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    busy_d  = (state_d == COUNT);
    valid_d = (state_d == HOLD);
  end

  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res         = res_q;
  assign err_ovf     = ovf_q;
  assign err_timeout = tmo_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_unary_rx.sv
// Bench for unary_rx: directed frames plus random traffic, all outputs checked
// every cycle against a frame-level model using an unsaturated pulse count.
module tb_unary_rx;

  localparam int WIDTH   = 4;
  localparam int CW      = 8;
  localparam int MAXV    = 225;
  localparam int TIMEOUT = 300;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          uin;
  logic          udone;
  logic          out_ready;
  logic          busy;
  logic          res_valid;
  logic [CW-1:0] res;
  logic          err_ovf;
  logic          err_timeout;
  logic          err_overrun;

  int vectors;
  int miscompares;
  bit checkEn;

  // Model: frame phase (0 idle, 1 counting, 2 holding) and raw pulse count.
  int mPhase;
  int mRaw;
  int mCycles;
  int mHeld;
  bit mTimedOut;
  bit mOverrun;

  unary_rx #(
    .WIDTH(WIDTH), .CW(CW), .MAXV(MAXV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .uin(uin), .udone(udone),
    .out_ready(out_ready), .busy(busy), .res_valid(res_valid), .res(res),
    .err_ovf(err_ovf), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mPhase = 0; mRaw = 0; mCycles = 0; mHeld = 0; mTimedOut = 0; mOverrun = 0;
    end else begin
      case (mPhase)
        0: if (start) begin
          mPhase = 1; mRaw = 0; mCycles = 0; mTimedOut = 0;
        end
        1: begin
          if (start) begin
            mRaw = 0; mCycles = 0; mTimedOut = 0;
          end else begin
            mRaw    = mRaw + (uin ? 1 : 0);
            mCycles = mCycles + 1;
            if (udone || mCycles == TIMEOUT) begin
              mPhase    = 2;
              mHeld     = (mRaw > MAXV) ? MAXV : mRaw;
              mTimedOut = !udone;
            end
          end
        end
        default: begin
          if (out_ready) begin
            mPhase = start ? 1 : 0;
            if (start) begin
              mRaw = 0; mCycles = 0; mTimedOut = 0;
            end
          end else if (start) begin
            mOverrun = 1;
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",        32'(busy),        32'(mPhase == 1));
      checkOutput("res_valid",   32'(res_valid),   32'(mPhase == 2));
      checkOutput("res",         32'(res),         32'(mHeld));
      checkOutput("err_ovf",     32'(err_ovf),     32'(mRaw > MAXV));
      checkOutput("err_timeout", 32'(err_timeout), 32'(mTimedOut));
      checkOutput("err_overrun", 32'(err_overrun), 32'(mOverrun));
    end
  end

  // Inputs are set 2ns after a rising edge and take effect at the next one.
  task automatic applyStimulus(input logic s, input logic u, input logic d, input logic r);
    start = s; uin = u; udone = d; out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] pat;
    vectors = 0; miscompares = 0; checkEn = 0;
    start = 0; uin = 0; udone = 0; out_ready = 0;
    reset_n = 0;
    #12;
    checkOutput("reset_busy",  32'(busy),      32'd0);
    checkOutput("reset_valid", 32'(res_valid), 32'd0);
    checkOutput("reset_res",   32'(res),       32'd0);
    @(posedge clk); #2;
    reset_n = 1;
    checkEn = 1;

    // Six gapped pulses then udone.
    applyStimulus(1, 0, 0, 0);
    pat = 10'b1011001101;
    for (int i = 0; i < 10; i++) applyStimulus(0, pat[i], 0, 0);
    checkOutput("t1_busy_before_done", 32'(busy), 32'd1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t1_res",       32'(res),         32'd6);
    checkOutput("t1_model_res", 32'(mHeld),       32'd6);
    checkOutput("t1_valid",     32'(res_valid),   32'd1);
    checkOutput("t1_ovf",       32'(err_ovf),     32'd0);
    checkOutput("t1_tmo",       32'(err_timeout), 32'd0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("t1_valid_after_accept", 32'(res_valid), 32'd0);
    checkOutput("t1_res_held",           32'(res),       32'd6);
    idleCycles(3);

    // Exactly MAXV pulses, last one coinciding with udone.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 224; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t2_res",       32'(res),     32'd225);
    checkOutput("t2_model_res", 32'(mHeld),   32'd225);
    checkOutput("t2_ovf",       32'(err_ovf), 32'd0);
    applyStimulus(0, 0, 0, 1);
    idleCycles(2);

    // Beyond MAXV saturates and flags overflow.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 230; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t3_res", 32'(res),     32'd225);
    checkOutput("t3_ovf", 32'(err_ovf), 32'd1);
    applyStimulus(0, 0, 0, 1);
    idleCycles(2);

    // Timeout after TIMEOUT counting cycles.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
    idleCycles(289);
    checkOutput("t4_busy_at_299", 32'(busy), 32'd1);
    idleCycles(1);
    checkOutput("t4_res",   32'(res),         32'd10);
    checkOutput("t4_tmo",   32'(err_timeout), 32'd1);
    checkOutput("t4_valid", 32'(res_valid),   32'd1);

    // Start while holding an unaccepted result, then back-to-back accept+start.
    idleCycles(2);
    applyStimulus(1, 0, 0, 0);
    idleCycles(2);
    checkOutput("t5_overrun", 32'(err_overrun), 32'd1);
    checkOutput("t5_res",     32'(res),         32'd10);
    checkOutput("t5_valid",   32'(res_valid),   32'd1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t5_busy_b2b",  32'(busy),      32'd1);
    checkOutput("t5_valid_b2b", 32'(res_valid), 32'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("t5_res2", 32'(res), 32'd2);
    applyStimulus(0, 0, 0, 1);
    idleCycles(2);

    // Asynchronous reset mid-frame.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 0, 0);
    reset_n = 0;
    #1;
    checkOutput("t6_busy",    32'(busy),        32'd0);
    checkOutput("t6_valid",   32'(res_valid),   32'd0);
    checkOutput("t6_res",     32'(res),         32'd0);
    checkOutput("t6_overrun", 32'(err_overrun), 32'd0);
    checkOutput("t6_ovf",     32'(err_ovf),     32'd0);
    checkOutput("t6_tmo",     32'(err_timeout), 32'd0);
    #1;
    reset_n = 1;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0);
    checkOutput("t6_no_valid", 32'(res_valid), 32'd0);
    idleCycles(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)));
    end

    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
